// File: rtl/watch_pkg.sv
// Shared mode encoding, field limits and widths
// for the watch timekeeping core.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_BAD     = 2'b11
  } mode_e;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

endpackage

// File: rtl/watch_time_set_mod_counter.sv
// Wrapping 0..MAX counter with clear, enable
// and an enable-qualified carry out.
module mod_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             carry
);

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MAX);

  assign carry = en && (q == QMAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == QMAX) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/watch_time_set.sv
// Watch timekeeping core: prescaled h:m:s time
// plus the RUN / SET_HR / SET_MIN set-mode FSM.
module watch_time_set
  import watch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_tick,
  input  logic              inc_tick,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec,
  output logic [1:0]        mode,
  output logic              sec_pulse,
  output logic              blink
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] P_HALF = PW'(TICKS_PER_SEC / 2);

  mode_e         mode_q;
  mode_e         mode_d;
  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tc;
  logic          run;
  logic          adv;
  logic          leave;
  logic          hr_inc;
  logic          min_inc;
  logic          sec_c;
  logic          min_c;
  logic          hour_c;
  logic          blink_d;

  assign tc      = (pre_q == P_LAST);
  assign run     = (mode_q == MODE_RUN);
  assign adv     = run && tc;
  assign leave   = (mode_q == MODE_SET_MIN) && mode_tick;
  assign hr_inc  = (mode_q == MODE_SET_HR) && inc_tick && !mode_tick;
  assign min_inc = (mode_q == MODE_SET_MIN) && inc_tick && !mode_tick;

  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      MODE_RUN:     if (mode_tick) mode_d = MODE_SET_HR;
      MODE_SET_HR:  if (mode_tick) mode_d = MODE_SET_MIN;
      MODE_SET_MIN: if (mode_tick) mode_d = MODE_RUN;
      default:      mode_d = MODE_RUN;
    endcase
  end

  // Returning to RUN restarts the second from zero.
  always_comb begin
    pre_d   = (leave || tc) ? '0 : pre_q + 1'b1;
    blink_d = (mode_d == MODE_SET_HR || mode_d == MODE_SET_MIN)
              && (pre_d < P_HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_RUN;
      pre_q     <= '0;
      sec_pulse <= 1'b0;
      blink     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pre_q     <= pre_d;
      sec_pulse <= adv;
      blink     <= blink_d;
    end
  end

  mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .clr   (leave),
    .en    (adv),
    .q     (sec),
    .carry (sec_c)
  );

  // Set-mode bumps bypass the chain; carries only ripple in RUN.
  mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    ((sec_c && run) || min_inc),
    .q     (min),
    .carry (min_c)
  );

  mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    ((min_c && run) || hr_inc),
    .q     (hour),
    .carry (hour_c)
  );

  assign mode = mode_q;

endmodule

// File: tb/tb_watch_time_set.sv
// Scoreboard bench for watch_time_set with a
// behavioural time/mode model, TICKS_PER_SEC=4.
module tb_watch_time_set;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_tick = 1'b0;
  logic       inc_tick = 1'b0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] mode;
  logic       sec_pulse;
  logic       blink;

  watch_time_set #(.TICKS_PER_SEC(TPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_tick (mode_tick),
    .inc_tick  (inc_tick),
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .mode      (mode),
    .sec_pulse (sec_pulse),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int m;
    int s;
    int md;
    int sp;
    int bl;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  int m_p = 0, m_h = 0, m_m = 0, m_s = 0, m_md = 0, m_sp = 0, m_bl = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit mt, input bit it);
    int  nmd;
    bit  tc;
    bit  clr;
    if (r) begin
      m_p = 0; m_h = 0; m_m = 0; m_s = 0;
      m_md = 0; m_sp = 0; m_bl = 0;
      return;
    end
    tc   = (m_p == TPS - 1);
    clr  = 1'b0;
    nmd  = m_md;
    m_sp = 0;
    case (m_md)
      0: begin
        if (tc) begin
          m_sp = 1;
          m_s++;
          if (m_s == 60) begin
            m_s = 0;
            m_m++;
            if (m_m == 60) begin
              m_m = 0;
              m_h = (m_h + 1) % 24;
            end
          end
        end
        if (mt) nmd = 1;
      end
      1: begin
        if (mt) nmd = 2;
        else if (it) m_h = (m_h + 1) % 24;
      end
      2: begin
        if (mt) begin
          nmd = 0;
          m_s = 0;
          clr = 1'b1;
        end else if (it) begin
          m_m = (m_m + 1) % 60;
        end
      end
      default: nmd = 0;
    endcase
    m_md = nmd;
    m_p  = (clr || tc) ? 0 : m_p + 1;
    m_bl = (m_md != 0 && m_p < TPS / 2) ? 1 : 0;
  endtask

  task automatic cyc(input bit r, input bit mt, input bit it);
    exp_t e;
    @(negedge clk);
    rst = r;
    mode_tick = mt;
    inc_tick = it;
    model(r, mt, it);
    e = '{m_h, m_m, m_s, m_md, m_sp, m_bl};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("hour", int'(hour), e.h);
      chk("min", int'(min), e.m);
      chk("sec", int'(sec), e.s);
      chk("mode", int'(mode), e.md);
      chk("sec_pulse", int'(sec_pulse), e.sp);
      chk("blink", int'(blink), e.bl);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1);
  endtask

  initial begin
    int npulse;
    int nblink;
    int s0;

    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rst_hour", int'(hour), 0);
    chk("rst_mode", int'(mode), 0);
    idle(3);
    chk("pre_pulse", int'(sec_pulse), 0);
    idle(1);
    chk("first_pulse", int'(sec_pulse), 1);
    chk("first_sec", int'(sec), 1);

    cyc(0, 1, 0);
    incs(23);
    cyc(0, 1, 0);
    incs(59);
    chk("preload_hr", int'(hour), 23);
    chk("preload_min", int'(min), 59);
    cyc(0, 1, 0);
    chk("run_sec_clr", int'(sec), 0);
    npulse = 0;
    for (int i = 0; i < 60 * TPS; i++) begin
      cyc(0, 0, 0);
      if (sec_pulse) npulse++;
    end
    chk("pulse_count", npulse, 60);
    chk("wrap_time", int'({hour, min, sec}), 0);

    cyc(0, 1, 0);
    s0 = int'(sec);
    incs(25);
    chk("hr_wrap", int'(hour), 1);
    chk("hr_mode", int'(mode), 1);
    nblink = 0;
    for (int i = 0; i < 2 * TPS; i++) begin
      cyc(0, 0, 0);
      if (blink) nblink++;
    end
    chk("blink_duty", nblink, TPS);
    chk("sec_frozen", int'(sec), s0);

    incs(4);
    cyc(0, 1, 0);
    incs(59);
    cyc(0, 0, 1);
    chk("min_wrap", int'(min), 0);
    chk("min_nocarry", int'(hour), 5);
    cyc(0, 1, 0);
    chk("ret_run", int'(mode), 0);
    idle(3);
    chk("ret_nopulse", int'(sec_pulse), 0);
    idle(1);
    chk("ret_pulse", int'(sec_pulse), 1);

    idle(3);
    cyc(0, 1, 0);
    chk("tc_mode_pulse", int'(sec_pulse), 1);
    cyc(0, 1, 1);
    chk("both_mode", int'(mode), 2);
    chk("both_hour", int'(hour), 5);

    cyc(0, 1, 0);
    cyc(0, 1, 0);
    incs(2);
    cyc(0, 1, 0);
    incs(33);
    chk("set_0733", int'(hour) * 100 + int'(min), 733);
    cyc(1, 0, 0);
    chk("rst_mid_mode", int'(mode), 0);
    chk("rst_mid_time", int'({hour, min, sec}), 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("run_inc_ign", int'(hour) + int'(min), 0);
    idle(8);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/watch_time_set.md
Name: watch_time_set

Overview:
- Timekeeping core of the digital watch; sits directly downstream of the pushbutton one-shot stage and consumes its single-cycle tick pulses.
- Keeps the hour:minute:second time, advanced by a clk prescaler.
- Runs a three-state set-mode FSM: MODE button cycles through modes, INC button bumps the selected field.
- Outputs feed the display/BCD stage.

Parameters:
- TICKS_PER_SEC, 1000, clk cycles per second; must be >= 2; prescaler width = $clog2(TICKS_PER_SEC).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- mode_tick  input  1  one-cycle pulse from the MODE button one-shot.
- inc_tick  input  1  one-cycle pulse from the INC button one-shot.
- hour  output  5  hours, 0..23.
- min  output  6  minutes, 0..59.
- sec  output  6  seconds, 0..59.
- mode  output  2  current mode: 00 RUN, 01 SET_HR, 10 SET_MIN.
- sec_pulse  output  1  one-cycle pulse when sec advances (RUN only).
- blink  output  1  display blink enable for the field being set.

Behaviour:
- Reset (rst=1 at a rising edge):
  - hour=0, min=0, sec=0, mode=RUN, prescaler=0, sec_pulse=0, blink=0.
  - Reset overrides all other inputs in the same cycle, including mid-set.
- All outputs are registered. An input tick at edge N is visible on the outputs after edge N.
- Prescaler:
  - Free-runs 0..TICKS_PER_SEC-1 in every mode, then wraps to 0.
  - Terminal count is prescaler==TICKS_PER_SEC-1.
- RUN mode, at terminal count:
  - sec_pulse=1 for exactly one cycle.
  - sec increments. At 59, sec wraps to 0 and min increments. At 59, min wraps to 0 and hour increments. At 23, hour wraps to 0.
  - 23:59:59 goes to 00:00:00 in a single edge.
- SET_HR and SET_MIN modes:
  - Time does not advance and sec_pulse stays 0.
  - blink = 1 while prescaler < TICKS_PER_SEC/2, else 0.
- blink is 0 in RUN.
- FSM on mode_tick: RUN -> SET_HR -> SET_MIN -> RUN. Encoding 11 is illegal; it goes to RUN on the next edge.
- Leaving SET_MIN for RUN clears sec and prescaler to 0 in that same edge, so the next second begins one full period later.
- inc_tick:
  - In SET_HR: hour = (hour+1) mod 24.
  - In SET_MIN: min = (min+1) mod 60, with no carry into hour. sec is unchanged.
  - In RUN: ignored.
- Simultaneous mode_tick and inc_tick: the mode change wins and inc_tick is dropped.
- In RUN, a mode_tick coinciding with terminal count: the time advance and sec_pulse still occur, and mode becomes SET_HR.
- Entering SET_HR does not clear sec or prescaler.
- Back-to-back ticks on consecutive cycles are each honoured.

Decomposition:
- Package watch_pkg holds:
  - mode encoding constants MODE_RUN, MODE_SET_HR, MODE_SET_MIN;
  - limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
  - field widths HOUR_W=5, MIN_W=6, SEC_W=6.
- One sub-module, mod_counter:
  - parameters WIDTH, MAX;
  - ports clk, rst, clr, en, q, carry;
  - carry = en && q==MAX; q wraps to 0.
  - Instantiated three times for sec, min and hour.
  - The set-mode increment drives each counter's en directly, with its carry masked.

Test Plan (TICKS_PER_SEC=4 in bench):
- rst held 2 cycles, then released -> all outputs 0, mode=00. sec_pulse first asserted 4 cycles after release, and sec=1 then.
- Preload via set mode to 23:59, return to RUN, run 60 s -> sec_pulse sequence ends at 00:00:00. hour, min and sec wrap on the same edge.
- mode_tick, then 25 inc_ticks -> mode=01, hour=1 (wraps past 23). sec frozen. blink toggles with period 4 cycles, high for 2.
- Go to SET_MIN at min=59 and hour=5, then one inc_tick -> min=0, hour stays 5. A further mode_tick -> mode=00, sec=0, next sec_pulse 4 cycles later.
- mode_tick and inc_tick asserted in the same cycle in SET_HR -> mode=10, hour unchanged.
- rst asserted while in SET_MIN with time 07:33 -> next cycle all zero and mode=00. inc_tick in RUN -> no change.
